// File: rtl/bitwise_logic_unit_pkg.sv
// Shared op-code definitions for the bitwise logic unit and its combinational core.
package blu_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_AND    = 3'b000;
  localparam op_t OP_OR     = 3'b001;
  localparam op_t OP_XOR    = 3'b010;
  localparam op_t OP_NOR    = 3'b011;
  localparam op_t OP_NAND   = 3'b100;
  localparam op_t OP_XNOR   = 3'b101;
  localparam op_t OP_NOT    = 3'b110;
  localparam op_t OP_ACC_OR = 3'b111;

endpackage

// File: rtl/bitwise_logic_unit_op_core.sv
// Purely combinational op evaluator: selects one of eight bitwise functions of a, b
// and the (already clear-adjusted) accumulator value.
module bitwise_op_core
  import blu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] r
);

  // Decode the op field into the selected bitwise function.
  always_comb begin
    r = '0;
    case (op)
      OP_AND:    r = a & b;
      OP_OR:     r = a | b;
      OP_XOR:    r = a ^ b;
      OP_NOR:    r = ~(a | b);
      OP_NAND:   r = ~(a & b);
      OP_XNOR:   r = ~(a ^ b);
      OP_NOT:    r = ~a;
      OP_ACC_OR: r = acc | a | b;
      default:   r = '0;
    endcase
  end

endmodule

// File: rtl/bitwise_logic_unit.sv
// Registered WIDTH-bit logic unit behind a valid/ready handshake: one-cycle latency,
// zero/all-ones flags, OR-accumulator and a wrapping accepted-beat counter.
module bitwise_logic_unit
  import blu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_o,
  output logic             out_zero,
  output logic             out_ones,
  output logic [CNT_W-1:0] beat_cnt
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_eff;
  logic [WIDTH-1:0] result;
  logic             accept;
  logic             acc_beat;

  // The result register frees up when empty or when its content is consumed this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign acc_beat = accept && (in_op == OP_ACC_OR);

  // A clear arriving with an ACC_OR beat acts first, so the core sees an empty accumulator.
  assign acc_eff = acc_clr ? '0 : acc;

  bitwise_op_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .op (in_op),
    .a  (in_a),
    .b  (in_b),
    .acc(acc_eff),
    .r  (result)
  );

  // Result, flags, valid and beat counter update together on acceptance; valid drops on drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_o     <= '0;
      out_zero  <= 1'b1;
      out_ones  <= 1'b0;
      beat_cnt  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_o     <= result;
      out_zero  <= (result == '0);
      out_ones  <= &result;
      beat_cnt  <= beat_cnt + CNT_W'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Accumulator follows accepted ACC_OR beats and is otherwise only touched by a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (acc_beat) begin
      acc <= result;
    end else if (acc_clr) begin
      acc <= '0;
    end
  end

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Scoreboard bench: three units (4-bit/8-bit count, 4-bit/2-bit count, 16-bit) share
// one stimulus stream; expected results are queued on acceptance and popped by a monitor.
module tb_bitwise_logic_unit;
  import blu_pkg::*;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        acc_clr   = 1'b0;
  logic        out_ready = 1'b0;
  logic [2:0]  in_op     = 3'b000;
  logic [15:0] in_a      = '0;
  logic [15:0] in_b      = '0;

  logic        r4_ready, r4_valid, r4_zero, r4_ones;
  logic [3:0]  r4_o;
  logic [7:0]  r4_cnt;
  logic        rc_ready, rc_valid, rc_zero, rc_ones;
  logic [3:0]  rc_o;
  logic [1:0]  rc_cnt;
  logic        r16_ready, r16_valid, r16_zero, r16_ones;
  logic [15:0] r16_o;
  logic [7:0]  r16_cnt;

  typedef struct {
    logic [3:0]  o4;
    logic [15:0] o16;
    int          beat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   beats    = 0;
  int   n_pushed = 0;
  int   n_popped = 0;

  bitwise_logic_unit #(.WIDTH(4), .CNT_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r4_ready), .in_op(in_op),
    .in_a(in_a[3:0]), .in_b(in_b[3:0]), .acc_clr(acc_clr), .out_valid(r4_valid),
    .out_ready(out_ready), .out_o(r4_o), .out_zero(r4_zero), .out_ones(r4_ones),
    .beat_cnt(r4_cnt)
  );

  bitwise_logic_unit #(.WIDTH(4), .CNT_W(2)) dutc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rc_ready), .in_op(in_op),
    .in_a(in_a[3:0]), .in_b(in_b[3:0]), .acc_clr(acc_clr), .out_valid(rc_valid),
    .out_ready(out_ready), .out_o(rc_o), .out_zero(rc_zero), .out_ones(rc_ones),
    .beat_cnt(rc_cnt)
  );

  bitwise_logic_unit #(.WIDTH(16), .CNT_W(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r16_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .acc_clr(acc_clr), .out_valid(r16_valid),
    .out_ready(out_ready), .out_o(r16_o), .out_zero(r16_zero), .out_ones(r16_ones),
    .beat_cnt(r16_cnt)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [3:0] x4, input logic [15:0] x16);
    exp_t e;
    beats++;
    e.o4   = x4;
    e.o16  = x16;
    e.beat = beats;
    sb.push_back(e);
    n_pushed++;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Drive one beat and hold it until accepted; queue its expected result on acceptance.
  task automatic apply_stimulus(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                input logic clr, input logic [3:0] x4, input logic [15:0] x16);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    acc_clr  = clr;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (r4_ready) begin
        push_exp(x4, x16);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL accept timeout: got in_ready=0, expected acceptance within 50 cycles");
    end
    in_valid = 1'b0;
    acc_clr  = 1'b0;
  endtask

  // Monitor: every consumed result is compared against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && r4_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected result: got out_o=0x%0h, expected no pending result", r4_o);
      end else begin
        e = sb.pop_front();
        n_popped++;
        check_output("w4 out_o",       32'(r4_o),     32'(e.o4));
        check_output("w4 out_zero",    32'(r4_zero),  32'(e.o4 == 4'h0));
        check_output("w4 out_ones",    32'(r4_ones),  32'(&e.o4));
        check_output("w4 beat_cnt",    32'(r4_cnt),   32'(e.beat[7:0]));
        check_output("c2 out_o",       32'(rc_o),     32'(e.o4));
        check_output("c2 beat_cnt",    32'(rc_cnt),   32'(e.beat[1:0]));
        check_output("c2 out_valid",   32'(rc_valid), 32'(1));
        check_output("w16 out_o",      32'(r16_o),    32'(e.o16));
        check_output("w16 out_zero",   32'(r16_zero), 32'(e.o16 == 16'h0));
        check_output("w16 out_ones",   32'(r16_ones), 32'(&e.o16));
        check_output("w16 beat_cnt",   32'(r16_cnt),  32'(e.beat[7:0]));
        check_output("w16 out_valid",  32'(r16_valid), 32'(1));
      end
    end
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected end of test before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence.
  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset out_valid", 32'(r4_valid), 32'(0));
    check_output("reset out_o",     32'(r4_o),     32'(0));
    check_output("reset out_zero",  32'(r4_zero),  32'(1));
    check_output("reset out_ones",  32'(r4_ones),  32'(0));
    check_output("reset beat_cnt",  32'(r4_cnt),   32'(0));
    check_output("reset w16 zero",  32'(r16_zero), 32'(1));
    check_output("reset in_ready",  32'(r4_ready), 32'(1));

    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    cycle();

    apply_stimulus(OP_OR, 16'h0006, 16'h0004, 1'b0, 4'h6, 16'h0006);
    @(negedge clk);
    check_output("out_valid after OR", 32'(r4_valid), 32'(1));
    cycle();

    apply_stimulus(OP_AND,  16'hCCCC, 16'hAAAA, 1'b0, 4'h8, 16'h8888);
    apply_stimulus(OP_OR,   16'hCCCC, 16'hAAAA, 1'b0, 4'hE, 16'hEEEE);
    apply_stimulus(OP_XOR,  16'hCCCC, 16'hAAAA, 1'b0, 4'h6, 16'h6666);
    apply_stimulus(OP_NOR,  16'hCCCC, 16'hAAAA, 1'b0, 4'h1, 16'h1111);
    apply_stimulus(OP_NAND, 16'hCCCC, 16'hAAAA, 1'b0, 4'h7, 16'h7777);
    apply_stimulus(OP_XNOR, 16'hCCCC, 16'hAAAA, 1'b0, 4'h9, 16'h9999);
    apply_stimulus(OP_NOT,  16'hCCCC, 16'hAAAA, 1'b0, 4'h3, 16'h3333);
    apply_stimulus(OP_NOR,  16'hFFFF, 16'h0000, 1'b0, 4'h0, 16'h0000);
    apply_stimulus(OP_NOR,  16'h0000, 16'h0000, 1'b0, 4'hF, 16'hFFFF);

    apply_stimulus(OP_ACC_OR, 16'h0001, 16'h0000, 1'b0, 4'h1, 16'h0001);
    apply_stimulus(OP_ACC_OR, 16'h0000, 16'h0002, 1'b0, 4'h3, 16'h0003);
    apply_stimulus(OP_ACC_OR, 16'h0004, 16'h0000, 1'b0, 4'h7, 16'h0007);
    apply_stimulus(OP_ACC_OR, 16'h0008, 16'h0000, 1'b1, 4'h8, 16'h0008);
    cycle();
    acc_clr = 1'b1;
    cycle();
    acc_clr = 1'b0;
    check_output("acc after clear",       32'(dut4.acc), 32'(0));
    check_output("out_o kept over clear", 32'(r4_o),     32'(8));
    apply_stimulus(OP_ACC_OR, 16'h0000, 16'h0000, 1'b0, 4'h0, 16'h0000);
    apply_stimulus(OP_ACC_OR, 16'h0005, 16'h0000, 1'b0, 4'h5, 16'h0005);
    apply_stimulus(OP_AND,    16'hFFFF, 16'hFFFF, 1'b0, 4'hF, 16'hFFFF);
    apply_stimulus(OP_ACC_OR, 16'h0000, 16'h0002, 1'b0, 4'h7, 16'h0007);
    cycle();

    out_ready = 1'b0;
    apply_stimulus(OP_XOR, 16'h0003, 16'h0005, 1'b0, 4'h6, 16'h0006);
    in_valid = 1'b1;
    in_op    = OP_AND;
    in_a     = 16'h000F;
    in_b     = 16'h0009;
    repeat (5) begin
      @(negedge clk);
      check_output("stall in_ready",  32'(r4_ready), 32'(0));
      check_output("stall out_valid", 32'(r4_valid), 32'(1));
      check_output("stall out_o",     32'(r4_o),     32'(6));
      check_output("stall w16 out_o", 32'(r16_o),    32'(16'h0006));
    end
    cycle();
    out_ready = 1'b1;
    @(negedge clk);
    check_output("release in_ready", 32'(r4_ready), 32'(1));
    push_exp(4'h9, 16'h0009);
    cycle();
    in_valid = 1'b0;
    cycle();
    cycle();
    check_output("drained queue", 32'(sb.size()), 32'(0));
    check_output("pop count",     32'(n_popped),  32'(n_pushed));

    out_ready = 1'b0;
    apply_stimulus(OP_ACC_OR, 16'h0007, 16'h0000, 1'b0, 4'h7, 16'h0007);
    check_output("pre-reset out_valid", 32'(r4_valid),   32'(1));
    check_output("pre-reset acc",       32'(dut4.acc),   32'(7));
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async rst out_valid",   32'(r4_valid),   32'(0));
    check_output("async rst beat_cnt",    32'(r4_cnt),     32'(0));
    check_output("async rst acc",         32'(dut4.acc),   32'(0));
    check_output("async rst c2 beat_cnt", 32'(rc_cnt),     32'(0));
    check_output("async rst w16 valid",   32'(r16_valid),  32'(0));
    check_output("async rst w16 acc",     32'(dut16.acc),  32'(0));
    sb.delete();
    beats    = 0;
    n_pushed = n_popped;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    cycle();
    apply_stimulus(OP_ACC_OR, 16'h0000, 16'h0000, 1'b0, 4'h0, 16'h0000);
    apply_stimulus(OP_XOR,    16'hF0F0, 16'h0F0F, 1'b0, 4'hF, 16'hFFFF);
    repeat (3) cycle();
    check_output("final drained queue", 32'(sb.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
